// File: rtl/axil_csr_bridge.sv
// AXI4-Lite slave bridge onto the single-cycle CSR bus: one outstanding write and one read, alternating arbitration.
// Define AXIL_CSR_BRIDGE_ERRCNT_EN to add the saturating SLVERR/DECERR counter (err_count / err_count_clr).
module axil_csr_bridge #(
    parameter int AXI_ADDR_W = 32,
    parameter int ADDR_W     = 8
) (
`ifdef AXIL_CSR_BRIDGE_ERRCNT_EN
    output logic [15:0]           err_count,
    input  logic                  err_count_clr,
`endif
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [AXI_ADDR_W-1:0] s_awaddr,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [31:0]           s_wdata,
    input  logic [3:0]            s_wstrb,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    input  logic [AXI_ADDR_W-1:0] s_araddr,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [31:0]           s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic                  csr_wen,
    output logic                  csr_ren,
    output logic [ADDR_W-1:0]     csr_addr,
    output logic [31:0]           csr_wdata,
    input  logic [31:0]           csr_rdata
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_RESP} state_t;
    typedef enum logic {GRANT_READ, GRANT_WRITE} grant_t;

    state_t                  state_q, state_d;
    grant_t                  lastGrant_q;
    logic                    awFull_q, wFull_q, arFull_q;
    logic [AXI_ADDR_W-1:0]   awAddr_q, arAddr_q;
    logic [31:0]             wData_q;
    logic [3:0]              wStrb_q;
    logic [ADDR_W-1:0]       csrAddr_q;
    logic [31:0]             csrWdata_q;
    logic [1:0]              bresp_q, rresp_q;
    logic [31:0]             rdata_q;

    logic wrPend, rdPend, grantWr, grantRd, bHs, rHs;
    logic awHigh, arHigh;
    logic [1:0] wrResp, rdResp;

    // Address bits beyond the CSR window decode to nothing; absent when the widths match.
    if (ADDR_W < AXI_ADDR_W) begin : gHighBits
        assign awHigh = |awAddr_q[AXI_ADDR_W-1:ADDR_W];
        assign arHigh = |arAddr_q[AXI_ADDR_W-1:ADDR_W];
    end else begin : gNoHighBits
        assign awHigh = 1'b0;
        assign arHigh = 1'b0;
    end

    function automatic logic [1:0] respFor(input logic highBits, input logic [1:0] lowBits,
                                           input logic badStrb);
        if (highBits)
            return RESP_DECERR;
        else if (lowBits != 2'b00 || badStrb)
            return RESP_SLVERR;
        else
            return RESP_OKAY;
    endfunction

    assign wrResp = respFor(awHigh, awAddr_q[1:0], wStrb_q != 4'hF);
    assign rdResp = respFor(arHigh, arAddr_q[1:0], 1'b0);

    assign wrPend    = awFull_q && wFull_q;
    assign rdPend    = arFull_q;
    assign bHs       = s_bvalid && s_bready;
    assign rHs       = s_rvalid && s_rready;
    assign s_awready = !awFull_q;
    assign s_wready  = !wFull_q;
    assign s_arready = !arFull_q;
    assign s_bresp   = bresp_q;
    assign s_rresp   = rresp_q;
    assign s_rdata   = rdata_q;
    assign csr_addr  = csrAddr_q;
    assign csr_wdata = csrWdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Valids and strobes decode from state so an asynchronous reset drops them at once.
    always_comb begin
        state_d  = state_q;
        grantWr  = 1'b0;
        grantRd  = 1'b0;
        csr_wen  = 1'b0;
        csr_ren  = 1'b0;
        s_bvalid = 1'b0;
        s_rvalid = 1'b0;
        case (state_q)
            IDLE: begin
                if (wrPend && (!rdPend || lastGrant_q == GRANT_READ)) begin
                    grantWr = 1'b1;
                    state_d = WR_ISSUE;
                end else if (rdPend) begin
                    grantRd = 1'b1;
                    state_d = RD_ISSUE;
                end
            end
            WR_ISSUE: begin
                csr_wen = (wrResp == RESP_OKAY);
                state_d = WR_RESP;
            end
            WR_RESP: begin
                s_bvalid = 1'b1;
                if (s_bready)
                    state_d = IDLE;
            end
            RD_ISSUE: begin
                csr_ren = (rdResp == RESP_OKAY);
                state_d = RD_RESP;
            end
            RD_RESP: begin
                s_rvalid = 1'b1;
                if (s_rready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awFull_q    <= 1'b0;
            wFull_q     <= 1'b0;
            arFull_q    <= 1'b0;
            awAddr_q    <= '0;
            arAddr_q    <= '0;
            wData_q     <= '0;
            wStrb_q     <= '0;
            csrAddr_q   <= '0;
            csrWdata_q  <= '0;
            bresp_q     <= RESP_OKAY;
            rresp_q     <= RESP_OKAY;
            rdata_q     <= '0;
            lastGrant_q <= GRANT_READ;
        end else begin
            if (s_awvalid && s_awready) begin
                awFull_q <= 1'b1;
                awAddr_q <= s_awaddr;
            end else if (bHs) begin
                awFull_q <= 1'b0;
            end
            if (s_wvalid && s_wready) begin
                wFull_q <= 1'b1;
                wData_q <= s_wdata;
                wStrb_q <= s_wstrb;
            end else if (bHs) begin
                wFull_q <= 1'b0;
            end
            if (s_arvalid && s_arready) begin
                arFull_q <= 1'b1;
                arAddr_q <= s_araddr;
            end else if (rHs) begin
                arFull_q <= 1'b0;
            end
            if (grantWr) begin
                csrAddr_q   <= awAddr_q[ADDR_W-1:0];
                csrWdata_q  <= wData_q;
                lastGrant_q <= GRANT_WRITE;
            end else if (grantRd) begin
                csrAddr_q   <= arAddr_q[ADDR_W-1:0];
                lastGrant_q <= GRANT_READ;
            end
            if (state_q == WR_ISSUE)
                bresp_q <= wrResp;
            if (state_q == RD_ISSUE) begin
                rresp_q <= rdResp;
                rdata_q <= (rdResp == RESP_OKAY) ? csr_rdata : 32'h0;
            end
        end
    end

`ifdef AXIL_CSR_BRIDGE_ERRCNT_EN
    logic [15:0] errCount_q;
    logic        errResp;

    assign errResp   = (bHs && s_bresp[1]) || (rHs && s_rresp[1]);
    assign err_count = errCount_q;

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            errCount_q <= '0;
        else if (err_count_clr)
            errCount_q <= '0;
        else if (errResp && errCount_q != 16'hFFFF)
            errCount_q <= errCount_q + 16'd1;
    end
`endif

endmodule

// File: doc/axil_csr_bridge.md
Name: axil_csr_bridge

Overview:
- AXI4-Lite slave shim that converts host AXI-Lite transactions into the single-cycle csr_wen/csr_ren/csr_addr/csr_wdata/csr_rdata bus of the accelerator CSR block.
- Sits between the SoC interconnect and the CSR block, as the AXI alternative to the UART bridge.
- One outstanding write and one outstanding read, alternating arbitration onto the shared CSR bus, and SLVERR/DECERR generation.

Parameters:
- AXI_ADDR_W, 32, AXI address width.
- ADDR_W, 8, CSR byte-address width forwarded on csr_addr; must be ≤ AXI_ADDR_W.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- s_awaddr  in  AXI_ADDR_W  write address
- s_awvalid / s_awready  in / out  1  AW handshake
- s_wdata  in  32  write data
- s_wstrb  in  4  byte strobes
- s_wvalid / s_wready  in / out  1  W handshake
- s_bresp  out  2  write response
- s_bvalid / s_bready  out / in  1  B handshake
- s_araddr  in  AXI_ADDR_W  read address
- s_arvalid / s_arready  in / out  1  AR handshake
- s_rdata  out  32  read data
- s_rresp  out  2  read response
- s_rvalid / s_rready  out / in  1  R handshake
- csr_wen  out  1  CSR write strobe, one cycle
- csr_ren  out  1  CSR read strobe, one cycle
- csr_addr  out  ADDR_W  CSR byte address (registered)
- csr_wdata  out  32  CSR write data (registered)
- csr_rdata  in  32  combinational CSR read data, valid in the csr_ren cycle

Behaviour:
- Reset values: awready=wready=arready=1; bvalid=rvalid=0; csr_wen=csr_ren=0; csr_addr=0; csr_wdata=0; bresp=rresp=0; s_rdata=0; FSM=IDLE; last_grant=READ.
- Holding registers aw_full, w_full, ar_full:
  - Each set on its channel handshake.
  - awready=!aw_full, wready=!w_full, arready=!ar_full.
  - AW and W may arrive in either order or in the same cycle.
- FSM states: IDLE, WR_ISSUE, WR_RESP, RD_ISSUE, RD_RESP.
- IDLE:
  - wr_pend = aw_full&&w_full; rd_pend = ar_full.
  - Both pending: grant the opposite of last_grant. Otherwise grant whichever is pending.
  - On grant, load csr_addr/csr_wdata from the held address/data (csr_wdata only for writes), update last_grant, move to the ISSUE state.
- WR_ISSUE: csr_wen=1 for this single cycle unless an error is flagged; latch bresp; next state WR_RESP.
- WR_RESP:
  - bvalid=1 until bready.
  - On the B handshake: clear aw_full and w_full, go to IDLE.
- RD_ISSUE:
  - csr_ren=1 unless an error is flagged.
  - Register csr_rdata into s_rdata on this edge; on error, s_rdata=0.
  - Latch rresp; next state RD_RESP.
- RD_RESP:
  - rvalid=1 until rready; s_rdata and rresp held stable.
  - On the R handshake: clear ar_full, go to IDLE.
- Latency, with the last of AW/W (or AR) handshaked in cycle N:
  - csr_wen or csr_ren asserted in cycle N+2.
  - bvalid or rvalid asserted from cycle N+3.
- Error rules, checked in priority order; an errored access never strobes the CSR:
  1. Any address bit at or above ADDR_W nonzero → DECERR (2'b11).
  2. addr[1:0]≠0 → SLVERR (2'b10).
  3. Write with wstrb≠4'hF → SLVERR.
  4. Otherwise → OKAY (2'b00).
- Unmapped-but-in-range CSR reads return whatever csr_rdata presents (0xDEADBEEF) with OKAY.
- csr_wen and csr_ren are never high in the same cycle; at most one CSR access per cycle.
- Back-pressure: a new AW/W is not accepted until the previous B handshake; a new AR is not accepted until the previous R handshake.
- Reset mid-transaction: all holding registers clear, FSM goes to IDLE, valids deassert immediately (asynchronously), no strobe is issued; the in-flight transaction is dropped.

Optional Feature:
- Macro AXIL_CSR_BRIDGE_ERRCNT_EN.
- Defined:
  - Adds output err_count [15:0] and input err_count_clr [0:0].
  - The counter increments once per SLVERR or DECERR response, on the B or R handshake; it saturates at 16'hFFFF.
  - err_count_clr=1 synchronously zeroes it and takes priority over an increment in the same cycle.
  - Reset value 0.
- Undefined: neither port exists and no counter logic is built; all other behaviour is identical.

Test Plan:
- AW 0x04 and W 0x0000_0010 (wstrb F) in the same cycle N → csr_wen=1 with csr_addr=0x04 and csr_wdata=0x10 only in N+2; bvalid in N+3 with bresp=OKAY.
- W first, AW three cycles later → csr_wen exactly once, two cycles after the AW handshake; wready=0 between the two handshakes.
- Read 0x3C with the CSR driving 0x0000_0003 → csr_ren in N+2; rvalid in N+3; rdata=0x3; rresp=OKAY; rready held low for 5 cycles → rdata stays stable.
- Write and read both pending in IDLE with last_grant=READ → write issued first, then the read; across two rounds of simultaneous requests, grants strictly alternate.
- Write to 0x05 → SLVERR, no csr_wen. Read from 0x100 (AXI_ADDR_W=32) → DECERR, rdata=0, no csr_ren. Write with wstrb=4'h3 → SLVERR, no csr_wen. With the macro defined, err_count=3 afterwards; err_count_clr → 0.
- rst_n low while in RD_RESP → rvalid=0 immediately; after release, arready=1, FSM in IDLE, no spurious csr_ren or csr_wen.
